// File: rtl/apb_pkg.sv
// ----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB-to-memory bridge.
//   state_e    : bridge FSM states (IDLE, REQ, RESP)
//   resp_t     : APB response {data, err} at the default data width
//   STRB_W     : byte-strobe width for the default data width
//   ctr_width  : width of the wait-state timeout counter for a given limit
//   sat_inc8   : saturating increment used by the error counter
// ----------------------------------------------------------------------------
package apb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int STRB_W     = DATA_W_DEF / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  err;
   } resp_t;

   // A limit of 0 disables the timeout; keep a 1-bit counter so the
   // instance stays well-formed.
   function automatic int ctr_width(input int limit);
      return (limit > 0) ? $clog2(limit + 1) : 1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/apb_mem_bridge_timeout.sv
// ----------------------------------------------------------------------------
// apb_timeout_ctr
// Counts cycles spent waiting on the memory device.
//   clk, reset : clock, synchronous active-low reset
//   clr        : restart the count at 0 (bridge entering REQ)
//   en         : count this cycle (bridge in REQ)
//   limit      : cycle count at which the wait is abandoned
//   expired    : count has reached limit; always 0 when TIMEOUT == 0
// The count stops at limit instead of wrapping, so expired stays asserted
// until the next clr.
// ----------------------------------------------------------------------------
module apb_timeout_ctr
   import apb_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clr,
   input  logic                          en,
   input  logic [ctr_width(TIMEOUT)-1:0] limit,
   output logic                          expired
);

   localparam int W = ctr_width(TIMEOUT);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != limit)) begin
         cnt <= cnt + W'(1);
      end
   end

   assign expired = (TIMEOUT != 0) && (cnt == limit);

endmodule

// File: rtl/apb_mem_bridge.sv
// ----------------------------------------------------------------------------
// apb_mem_bridge
// APB4 completer driving one memory-style device through a ce/ready handshake.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   id                : this completer's select code (non-zero)
//   psel, penable,
//   pwrite, paddr,
//   pwdata, pstrb     : APB request side (psel is encoded, matched against id)
//   prdata, pready,
//   pslverr           : APB response side, one-cycle pready pulse
//   mem_ce, mem_wren,
//   mem_rden, mem_addr,
//   mem_wdata, mem_be : registered device request, held for the whole REQ
//   mem_rdata,
//   mem_ready         : device read data and completion
//   err_cnt           : saturating count of pslverr responses
// Out-of-range addresses and zero-strobe writes are answered directly from
// IDLE without touching the device. A wait longer than TIMEOUT cycles is
// aborted with pslverr. If the requester drops its select mid-wait, the
// device access still runs to completion but no response is returned.
// ----------------------------------------------------------------------------
module apb_mem_bridge
   import apb_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 2,
   parameter int DEPTH   = 256,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ID_W-1:0]     id,
   input  logic [ID_W-1:0]     psel,
   input  logic                penable,
   input  logic                pwrite,
   input  logic [ADDR_W-1:0]   paddr,
   input  logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W/8-1:0] pstrb,
   output logic [DATA_W-1:0]   prdata,
   output logic                pready,
   output logic                pslverr,
   output logic                mem_ce,
   output logic                mem_wren,
   output logic                mem_rden,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   output logic [DATA_W/8-1:0] mem_be,
   input  logic [DATA_W-1:0]   mem_rdata,
   input  logic                mem_ready,
   output logic [7:0]          err_cnt
);

   localparam int CNT_W = ctr_width(TIMEOUT);

   state_e state;
   logic   orphan;      // select was lost during the current REQ
   logic   selected;
   logic   setup;
   logic   in_range;
   logic   zero_wr;
   logic   req_entry;
   logic   expired;

   assign selected  = (psel == id);
   assign setup     = (state == ST_IDLE) && selected && !penable;
   // One extra bit so DEPTH == 2**ADDR_W is representable.
   assign in_range  = ({1'b0, paddr} < (ADDR_W+1)'(DEPTH));
   assign zero_wr   = pwrite && (pstrb == '0);
   assign req_entry = setup && in_range && !zero_wr;

   apb_timeout_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (req_entry),
      .en      (state == ST_REQ),
      .limit   (CNT_W'(TIMEOUT)),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      // NOTE: every register here has a defined reset value (no storage
      // arrays), so the whole datapath is cleared, not just the FSM.
      if (!reset) begin
         state     <= ST_IDLE;
         orphan    <= 1'b0;
         prdata    <= '0;
         pready    <= 1'b0;
         pslverr   <= 1'b0;
         mem_ce    <= 1'b0;
         mem_wren  <= 1'b0;
         mem_rden  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         err_cnt   <= '0;
      end else begin
         // NOTE: non-blocking defaults; a later assignment in the same
         // edge overrides them, producing a one-cycle pready pulse.
         pready  <= 1'b0;
         pslverr <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (setup) begin
                  if (!in_range) begin
                     state   <= ST_RESP;
                     pready  <= 1'b1;
                     pslverr <= 1'b1;
                     err_cnt <= sat_inc8(err_cnt);
                  end else if (zero_wr) begin
                     state  <= ST_RESP;
                     pready <= 1'b1;
                  end else begin
                     state     <= ST_REQ;
                     orphan    <= 1'b0;
                     mem_ce    <= 1'b1;
                     mem_wren  <= pwrite;
                     mem_rden  <= !pwrite;
                     mem_addr  <= paddr;
                     mem_wdata <= pwdata;
                     mem_be    <= pwrite ? pstrb : '1;
                  end
               end
            end

            ST_REQ: begin
               // Device completion wins over a timeout in the same cycle.
               if (mem_ready || expired) begin
                  mem_ce   <= 1'b0;
                  mem_wren <= 1'b0;
                  mem_rden <= 1'b0;
                  if (orphan || !selected) begin
                     state <= ST_IDLE;
                  end else begin
                     state  <= ST_RESP;
                     pready <= 1'b1;
                     if (mem_ready) begin
                        if (mem_rden) prdata <= mem_rdata;
                     end else begin
                        pslverr <= 1'b1;
                        prdata  <= '0;
                        err_cnt <= sat_inc8(err_cnt);
                     end
                  end
               end else if (!selected) begin
                  orphan <= 1'b1;
               end
            end

            ST_RESP: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_bridge.sv
// ----------------------------------------------------------------------------
// tb_apb_mem_bridge
// Directed APB transfers against apb_mem_bridge (DEPTH=128, TIMEOUT=4) with a
// behavioural memory device. Each transfer pushes its expected response and
// pready cycle into a queue; an independent monitor pops on every pready.
// ----------------------------------------------------------------------------
module tb_apb_mem_bridge;
   import apb_pkg::*;

   localparam logic [1:0] ID = 2'd2;

   logic        clk;
   logic        reset;
   logic [1:0]  psel;
   logic        penable;
   logic        pwrite;
   logic [7:0]  paddr;
   logic [31:0] pwdata;
   logic [STRB_W-1:0] pstrb;
   logic [31:0] prdata;
   logic        pready;
   logic        pslverr;
   logic        mem_ce;
   logic        mem_wren;
   logic        mem_rden;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ready;
   logic [7:0]  err_cnt;

   typedef struct {
      resp_t rsp;
      int    cyc;
      bit    chk;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          ce_cnt = 0;
   int          ready_delay = 0;   // REQ cycles before mem_ready; -1 = never
   logic [3:0]  seen_be = '0;
   logic [31:0] mem [0:255];

   apb_mem_bridge #(
      .ADDR_W (8), .DATA_W (32), .ID_W (2), .DEPTH (128), .TIMEOUT (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .id        (ID),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .paddr     (paddr),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .prdata    (prdata),
      .pready    (pready),
      .pslverr   (pslverr),
      .mem_ce    (mem_ce),
      .mem_wren  (mem_wren),
      .mem_rden  (mem_rden),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .err_cnt   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_rdata = mem[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Memory device model: ready after ready_delay REQ cycles, writes commit
   // with byte enables in the cycle ready is raised.
   initial begin
      int req_idx;
      req_idx = 0;
      for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
      mem_ready = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_ce) begin
            mem_ready = (ready_delay >= 0) && (req_idx >= ready_delay);
            req_idx++;
            ce_cnt++;
            seen_be = mem_be;
            check("mem_onehot", {31'd0, mem_wren ^ mem_rden}, 32'd1);
            if (mem_ready && mem_wren)
               for (int b = 0; b < 4; b++)
                  if (mem_be[b]) mem[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
         end else begin
            req_idx   = 0;
            mem_ready = 1'b0;
         end
      end
   end

   // Response monitor.
   always @(negedge clk) begin
      if (reset && pready) begin
         if (sb.size() == 0) begin
            check("unexpected_pready", {31'd0, pready}, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("pready_cycle", cyc, e.cyc);
            check("pslverr", {31'd0, pslverr}, {31'd0, e.rsp.err});
            if (e.chk) check("prdata", prdata, e.rsp.data);
         end
      end
   end

   task automatic apb_xfer(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] rdata_exp,
                           input bit err_exp, input int lat, input bit chk);
      exp_t e;
      int   n;
      @(negedge clk);
      psel = ID; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      e.rsp.data = rdata_exp;
      e.rsp.err  = err_exp;
      e.cyc      = cyc + lat;
      e.chk      = chk;
      sb.push_back(e);
      @(negedge clk);
      penable = 1'b1;
      n = 0;
      while (!pready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!pready) begin
         check("pready_wait", 32'd0, 32'd1);
         sb.delete();
      end
      psel = '0; penable = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int ce0;
      reset = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      repeat (3) @(negedge clk);
      check("rst_pready",  {31'd0, pready},  32'd0);
      check("rst_pslverr", {31'd0, pslverr}, 32'd0);
      check("rst_prdata",  prdata, 32'd0);
      check("rst_mem_ce",  {31'd0, mem_ce},  32'd0);
      check("rst_be",      {28'd0, mem_be},  32'd0);
      check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
      reset = 1'b1;

      // Write then read, device ready immediately.
      apb_xfer(1, 8'h05, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 2, 0);
      apb_xfer(0, 8'h05, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2, 1);

      // Partial write merges with existing word.
      apb_xfer(1, 8'h06, 32'h1122_3344, 4'hF, 32'h0, 0, 2, 0);
      apb_xfer(1, 8'h06, 32'hAABB_CCDD, 4'b0011, 32'h0, 0, 2, 0);
      check("partial_be", {28'd0, seen_be}, 32'h3);
      apb_xfer(0, 8'h06, 32'h0, 4'h0, 32'h1122_CCDD, 0, 2, 1);

      // Zero-strobe write: no device access, immediate response.
      ce0 = ce_cnt;
      apb_xfer(1, 8'h06, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 1, 0);
      check("zero_strb_no_ce", ce_cnt - ce0, 32'd0);
      apb_xfer(0, 8'h06, 32'h0, 4'h0, 32'h1122_CCDD, 0, 2, 1);

      // Wait states: 3 low cycles, then ready in the same cycle the
      // counter hits the limit (completion wins), then a real timeout.
      ready_delay = 3;
      apb_xfer(0, 8'h05, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 5, 1);
      ready_delay = 4;
      apb_xfer(0, 8'h06, 32'h0, 4'h0, 32'h1122_CCDD, 0, 6, 1);
      check("no_tmo_err_cnt", {24'd0, err_cnt}, 32'd0);
      ready_delay = -1;
      apb_xfer(0, 8'h05, 32'h0, 4'h0, 32'h0, 1, 6, 1);
      check("tmo_err_cnt", {24'd0, err_cnt}, 32'd1);
      ready_delay = 0;

      // Address range: last valid word, then out of range.
      ce0 = ce_cnt;
      apb_xfer(0, 8'h80, 32'h0, 4'h0, 32'h0, 1, 1, 0);
      apb_xfer(1, 8'hFF, 32'h1234_5678, 4'hF, 32'h0, 1, 1, 0);
      check("range_no_ce", ce_cnt - ce0, 32'd0);
      check("range_err_cnt", {24'd0, err_cnt}, 32'd2 + 32'd1);
      apb_xfer(0, 8'h7F, 32'h0, 4'h0, 32'hA500_007F, 0, 2, 1);

      // Foreign select and access phase without setup are ignored.
      ce0 = ce_cnt;
      @(negedge clk); psel = 2'd1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
      @(negedge clk); penable = 1'b1;
      @(negedge clk); psel = ID;
      repeat (3) @(negedge clk);
      psel = '0; penable = 1'b0;
      @(negedge clk);
      check("ignored_no_ce", ce_cnt - ce0, 32'd0);

      // Select dropped mid-REQ: access finishes, no response, no error.
      ready_delay = 2;
      ce0 = ce_cnt;
      @(negedge clk); psel = ID; penable = 1'b0; pwrite = 1'b0; paddr = 8'h05;
      @(negedge clk); psel = '0;
      repeat (5) @(negedge clk);
      check("orphan_ce_cycles", ce_cnt - ce0, 32'd3);
      check("orphan_mem_ce", {31'd0, mem_ce}, 32'd0);
      check("orphan_err_cnt", {24'd0, err_cnt}, 32'd3);
      ready_delay = 0;
      apb_xfer(0, 8'h06, 32'h0, 4'h0, 32'h1122_CCDD, 0, 2, 1);

      // Reset during REQ abandons the transfer.
      ready_delay = -1;
      @(negedge clk); psel = ID; penable = 1'b0; pwrite = 1'b1; paddr = 8'h09;
      pwdata = 32'hCAFE_F00D; pstrb = 4'hF;
      @(negedge clk); penable = 1'b1;
      check("pre_rst_mem_ce", {31'd0, mem_ce}, 32'd1);
      reset = 1'b0;
      @(negedge clk); reset = 1'b1; psel = '0; penable = 1'b0;
      check("mid_rst_mem_ce",   {31'd0, mem_ce},   32'd0);
      check("mid_rst_mem_wren", {31'd0, mem_wren}, 32'd0);
      check("mid_rst_addr",     {24'd0, mem_addr}, 32'd0);
      check("mid_rst_wdata",    mem_wdata, 32'd0);
      check("mid_rst_prdata",   prdata, 32'd0);
      check("mid_rst_err_cnt",  {24'd0, err_cnt}, 32'd0);
      ready_delay = 0;
      apb_xfer(0, 8'h05, 32'h0, 4'h0, 32'hDEAD_BEEF, 0, 2, 1);
      apb_xfer(0, 8'h09, 32'h0, 4'h0, 32'hA500_0009, 0, 2, 1);

      // Error counter saturation.
      for (int i = 0; i < 260; i++)
         apb_xfer(0, 8'h80 + 8'(i % 128), 32'h0, 4'h0, 32'h0, 1, 1, 0);
      check("err_cnt_sat", {24'd0, err_cnt}, 32'd255);

      repeat (3) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_mem_bridge.md
# apb_mem_bridge

Parametrised APB4 completer that bridges one APB port to a single attached memory-style device with a request/ready handshake. It is the next-generation APB slave: configurable address, data and select widths, byte strobes, address-range checking, a wait-state timeout with PSLVERR, and a saturating error counter. It sits between the APB master's select decode and any Memory_Bus peripheral.

## Interface
- ADDR_W, 8: word-address width of paddr/mem_addr.
- DATA_W, 32: data width; multiple of 8.
- ID_W, 2: width of psel and id.
- DEPTH, 256: number of valid word addresses, 0..DEPTH-1; must be ≤ 2^ADDR_W.
- TIMEOUT, 16: maximum cycles in REQ before abort; 0 disables the timeout.

- clk  in  1  the single clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- id  in  ID_W  this completer's select code; must be non-zero.
- psel  in  ID_W  encoded select; a transfer targets this block when psel == id.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  ADDR_W  word address.
- pwdata  in  DATA_W  write data.
- pstrb  in  DATA_W/8  write byte strobes.
- prdata  out  DATA_W  read data; valid only while pready=1.
- pready  out  1  transfer-complete strobe.
- pslverr  out  1  error response; valid only while pready=1.
- mem_ce  out  1  memory request active.
- mem_wren / mem_rden  out  1  write / read qualifier, one-hot while mem_ce=1.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_be  out  DATA_W/8  byte enables; all ones for reads.
- mem_rdata  in  DATA_W  device read data, sampled when mem_ready=1.
- mem_ready  in  1  device completion; may be tied high.
- err_cnt  out  8  count of error responses, saturating at 255.

## Operation
- FSM states are IDLE, REQ and RESP.
- IDLE → REQ: psel == id and penable=0 (setup phase). On this edge, latch paddr, pwdata, pwrite and pstrb (reads latch mem_be = all ones).
- IDLE → RESP, without a memory request, in two cases:
  - paddr ≥ DEPTH: respond with pslverr=1.
  - write with pstrb == 0: respond with pslverr=0.
- IDLE with penable=1 and no preceding setup: ignored.
- REQ:
  - mem_ce=1, and mem_wren or mem_rden set per the latched pwrite.
  - If mem_ready=1 at the edge: go to RESP. For reads, capture mem_rdata into prdata. Set pslverr=0.
  - Timeout counter clears on REQ entry and increments each REQ cycle. If it reaches TIMEOUT with mem_ready still 0: drop mem_ce, go to RESP with pslverr=1 and prdata=0.
- RESP: pready=1 for exactly one cycle, then IDLE.
  - A new setup may be accepted in the cycle after RESP.
  - err_cnt increments on entry to RESP whenever pslverr=1; it holds at 255.
- psel ≠ id while in REQ (protocol violation):
  - Finish the memory operation normally.
  - Suppress pready, return to IDLE, and do not count an error.
- Outputs outside REQ: mem_ce, mem_wren and mem_rden are 0.
- Outputs outside RESP: pready and pslverr are 0; prdata holds its last value.

## Timing
- Reset values: state IDLE, pready 0, pslverr 0, prdata 0, mem_ce 0, mem_wren 0, mem_rden 0, mem_addr 0, mem_wdata 0, mem_be 0, err_cnt 0, timeout counter 0.
- Reset asserted mid-transfer: outputs take reset values at the next edge and the transfer is abandoned.
- All outputs are registered.
- Setup at cycle T puts REQ in cycle T+1. With mem_ready=1 in T+1, pready=1 in T+2. Minimum transfer is therefore 3 cycles (one wait state).
- Each extra mem_ready=0 cycle adds one cycle.
- A timeout abort asserts pready at T+TIMEOUT+2.
- Error-path responses (out-of-range address, zero strobe) assert pready at T+1.

## Structure
- Package apb_pkg holds:
  - the state enum (IDLE, REQ, RESP);
  - a response struct {data, err};
  - the localparam STRB_W = DATA_W/8.
- Sub-module apb_timeout_ctr (ports: clr, en, limit, expired). Its width is $clog2(TIMEOUT+1). With TIMEOUT=0, expired is tied 0.

## Test plan
- Write then read: write addr 0x05, data 0xDEADBEEF, pstrb 4'hF, mem_ready tied 1 → pready at T+2, pslverr=0. A following read of 0x05 → prdata=0xDEADBEEF.
- Partial write: pstrb 4'b0011 → mem_be=4'b0011 while mem_ce=1. A write with pstrb 0 → no mem_ce, pready at T+1, pslverr=0.
- Wait states: mem_ready held low 5 cycles, TIMEOUT=16 → pready at T+7 with correct data. Set TIMEOUT=4 → pslverr=1 at T+6, prdata=0, err_cnt=1.
- Range and select: DEPTH=128, paddr 0x80 → pslverr=1 at T+1 with no mem_ce. psel ≠ id → no activity.
- Reset mid-REQ: drive reset=0 for one cycle → all outputs 0 next edge. A new transfer then completes normally.
- Counter saturation: 260 out-of-range accesses → err_cnt=255.
